// File: rtl/br_local_port_pkg.sv
// Shared types and constants for the BrLite local-port endpoint.
package br_local_port_pkg;

    localparam int BR_SEQ_W = 8;
    localparam int BR_SRC_W = 8;

    // Service message as exchanged with the NI and the BrLite router.
    typedef struct packed {
        logic [15:0] seq_source;
        logic [15:0] payload;
        logic [3:0]  ksvc;
    } br_payload_t;

    localparam int BR_PAYLOAD_W = $bits(br_payload_t);

    // Source id of a PE: {x, y} taken from the nibbles of its 16-bit address.
    function automatic logic [BR_SRC_W-1:0] br_src_id(input logic [15:0] address);
        return {address[11:8], address[3:0]};
    endfunction

endpackage

// File: rtl/br_local_port_if.sv
// NI-side and router-side signal bundle of the BrLite local port.
//
// Handshakes: every *_req/*_rx request is a level held by the requester until
// the matching ack pulse (one cycle) is seen; a transfer happens at the edge
// where the endpoint decides to accept, and the ack rises right after that
// edge. rt_req_o/rt_ack_i is a plain valid/ready pair: rt_data_o is stable
// while rt_req_o is high and the head is consumed at the edge where both are 1.
interface br_local_port_if;
    import br_local_port_pkg::*;

    logic        ni_req_i;
    logic        ni_ack_o;
    br_payload_t ni_data_i;
    logic        ni_busy_o;
    logic        ni_rx_o;
    br_payload_t ni_rx_data_o;
    logic        ni_rx_ack_i;
    logic        rt_req_o;
    logic        rt_ack_i;
    br_payload_t rt_data_o;
    logic        rt_rx_i;
    br_payload_t rt_rx_data_i;
    logic        rt_rx_ack_o;

    // Endpoint view.
    modport slave (
        input  ni_req_i, ni_data_i, ni_rx_ack_i, rt_ack_i, rt_rx_i, rt_rx_data_i,
        output ni_ack_o, ni_busy_o, ni_rx_o, ni_rx_data_o, rt_req_o, rt_data_o, rt_rx_ack_o
    );

    // Environment view (NI and router together).
    modport master (
        output ni_req_i, ni_data_i, ni_rx_ack_i, rt_ack_i, rt_rx_i, rt_rx_data_i,
        input  ni_ack_o, ni_busy_o, ni_rx_o, ni_rx_data_o, rt_req_o, rt_data_o, rt_rx_ack_o
    );

endinterface

// File: rtl/br_fifo.sv
// Synchronous FIFO: push is ignored when full, pop is ignored when empty,
// so a pop in a full cycle never makes room for a push in that same cycle.
module br_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/br_local_port.sv
// BrLite local-port endpoint: stamps and queues NI service messages towards
// the router, and queues router broadcasts (minus optional self-echoes) for
// the NI to read out. TX and RX paths are independent.
module br_local_port
    import br_local_port_pkg::*;
#(
    parameter logic [15:0] ADDRESS   = 16'h0000,
    parameter int          TX_DEPTH  = 4,
    parameter int          RX_DEPTH  = 4,
    parameter bit          DROP_SELF = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    br_local_port_if.slave  bus
);

    localparam logic [BR_SRC_W-1:0] OWN_ID  = br_src_id(ADDRESS);
    localparam logic [BR_SEQ_W-1:0] SEQ_ONE = 1;

    logic [BR_SEQ_W-1:0] seq;
    logic                ni_ack;
    logic                rt_rx_ack;
    logic                tx_full;
    logic                tx_empty;
    logic                rx_full;
    logic                rx_empty;
    logic                tx_accept;
    logic                rx_drop;
    logic                rx_accept;
    logic                rx_push;
    br_payload_t         tx_entry;
    br_payload_t         tx_head;
    br_payload_t         rx_head;
    logic                unused_ni_seq_source;

    // The NI's seq_source field is overwritten by the stamp below.
    assign unused_ni_seq_source = ^bus.ni_data_i.seq_source;

    // Accept while the previous ack is still high would double-push the
    // same request as the NI is only then dropping ni_req_i.
    assign tx_accept = bus.ni_req_i && !ni_ack && !tx_full;

    // Self-echo compare looks at the source byte only, not the sequence.
    assign rx_drop   = DROP_SELF && (bus.rt_rx_data_i.seq_source[BR_SRC_W-1:0] == OWN_ID);
    assign rx_accept = bus.rt_rx_i && !rt_rx_ack && (rx_drop || !rx_full);
    assign rx_push   = rx_accept && !rx_drop;

    // Outgoing entry: own sequence number and source id, NI payload and service.
    always_comb begin
        tx_entry            = '0;
        tx_entry.seq_source = {seq, OWN_ID};
        tx_entry.payload    = bus.ni_data_i.payload;
        tx_entry.ksvc       = bus.ni_data_i.ksvc;
    end

    // Sequence counter and the two one-cycle ack pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq       <= '0;
            ni_ack    <= 1'b0;
            rt_rx_ack <= 1'b0;
        end else begin
            ni_ack    <= tx_accept;
            rt_rx_ack <= rx_accept;
            if (tx_accept) begin
                seq <= seq + SEQ_ONE;
            end
        end
    end

    br_fifo #(
        .WIDTH (BR_PAYLOAD_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (tx_accept),
        .din   (tx_entry),
        .pop   (bus.rt_ack_i),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    br_fifo #(
        .WIDTH (BR_PAYLOAD_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (rx_push),
        .din   (bus.rt_rx_data_i),
        .pop   (bus.ni_rx_ack_i),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign bus.ni_ack_o     = ni_ack;
    assign bus.ni_busy_o    = !tx_empty;
    assign bus.rt_req_o     = !tx_empty;
    assign bus.rt_data_o    = tx_head;
    assign bus.rt_rx_ack_o  = rt_rx_ack;
    assign bus.ni_rx_o      = !rx_empty;
    assign bus.ni_rx_data_o = rx_head;

endmodule

// File: tb/tb_br_local_port.sv
// Bench for br_local_port: queue-level reference model with a per-cycle
// compare, plus directed scenarios with literal expectations.
module tb_br_local_port;
    import br_local_port_pkg::*;

    localparam logic [7:0] OWN = 8'h12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    br_local_port_if bus ();
    br_local_port_if bus2 ();

    br_local_port #(
        .ADDRESS   (16'h0102),
        .TX_DEPTH  (4),
        .RX_DEPTH  (4),
        .DROP_SELF (1'b1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    br_local_port #(
        .ADDRESS   (16'h0102),
        .TX_DEPTH  (4),
        .RX_DEPTH  (4),
        .DROP_SELF (1'b0)
    ) dut_keep (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (queues) ----------------
    logic [35:0] exp_tx_q[$];
    logic [35:0] exp_rx_q[$];
    logic [7:0]  m_seq;
    bit          m_ni_ack;
    bit          m_rx_ack;
    bit          m_valid;
    bit          acc_tx;
    bit          acc_rx;
    bit          pop_tx;
    bit          pop_rx;
    bit          m_drop;
    int          tx_n;
    int          rx_n;

    // Advance the model at each edge from the inputs the DUT sees.
    always @(posedge clk) begin
        if (rst) begin
            exp_tx_q.delete();
            exp_rx_q.delete();
            m_seq    = 8'h00;
            m_ni_ack = 1'b0;
            m_rx_ack = 1'b0;
            m_valid  = 1'b1;
        end else begin
            tx_n   = exp_tx_q.size();
            rx_n   = exp_rx_q.size();
            acc_tx = bus.ni_req_i && !m_ni_ack && (tx_n < 4);
            pop_tx = (tx_n > 0) && bus.rt_ack_i;
            m_drop = (bus.rt_rx_data_i.seq_source[7:0] == OWN);
            acc_rx = bus.rt_rx_i && !m_rx_ack && (m_drop || (rx_n < 4));
            pop_rx = bus.ni_rx_ack_i && (rx_n > 0);
            if (pop_tx) void'(exp_tx_q.pop_front());
            if (acc_tx) begin
                exp_tx_q.push_back({m_seq, OWN, bus.ni_data_i.payload, bus.ni_data_i.ksvc});
                m_seq = m_seq + 8'd1;
            end
            if (pop_rx) void'(exp_rx_q.pop_front());
            if (acc_rx && !m_drop) exp_rx_q.push_back(bus.rt_rx_data_i);
            m_ni_ack = acc_tx;
            m_rx_ack = acc_rx;
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ni_ack", bus.ni_ack_o, m_ni_ack);
            chk("rt_rx_ack", bus.rt_rx_ack_o, m_rx_ack);
            chk("ni_busy", bus.ni_busy_o, exp_tx_q.size() != 0);
            chk("rt_req", bus.rt_req_o, exp_tx_q.size() != 0);
            chk("ni_rx", bus.ni_rx_o, exp_rx_q.size() != 0);
            if (exp_tx_q.size() != 0) chk("rt_data", bus.rt_data_o, exp_tx_q[0]);
            if (exp_rx_q.size() != 0) chk("ni_rx_data", bus.ni_rx_data_o, exp_rx_q[0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] k, input logic [15:0] p);
        bit got;
        got = 1'b0;
        bus.ni_data_i = {16'hDEAD, p, k};
        bus.ni_req_i  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (bus.ni_ack_o) got = 1'b1;
        end
        bus.ni_req_i = 1'b0;
        chk("send_ack_seen", got, 1'b1);
    endtask

    task automatic deliver(input logic [35:0] d, input int max_cycles, output bit got);
        got = 1'b0;
        bus.rt_rx_data_i = d;
        bus.rt_rx_i      = 1'b1;
        for (int i = 0; i < max_cycles && !got; i++) begin
            tick();
            if (bus.rt_rx_ack_o) got = 1'b1;
        end
        bus.rt_rx_i = 1'b0;
    endtask

    task automatic ni_pop();
        bus.ni_rx_ack_i = 1'b1;
        tick();
        bus.ni_rx_ack_i = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    int          idx;
    int          n_acks;
    bit          got;
    logic [35:0] e;

    // ---------------- directed scenarios ----------------
    initial begin
        bus.ni_req_i      = 1'b0;
        bus.ni_data_i     = '0;
        bus.ni_rx_ack_i   = 1'b0;
        bus.rt_ack_i      = 1'b0;
        bus.rt_rx_i       = 1'b0;
        bus.rt_rx_data_i  = '0;
        bus2.ni_req_i     = 1'b0;
        bus2.ni_data_i    = '0;
        bus2.ni_rx_ack_i  = 1'b0;
        bus2.rt_ack_i     = 1'b0;
        bus2.rt_rx_i      = 1'b0;
        bus2.rt_rx_data_i = '0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_ni_ack", bus.ni_ack_o, 1'b0);
        chk("reset_rt_rx_ack", bus.rt_rx_ack_o, 1'b0);
        chk("reset_ni_busy", bus.ni_busy_o, 1'b0);
        chk("reset_ni_rx", bus.ni_rx_o, 1'b0);
        chk("reset_rt_req", bus.rt_req_o, 1'b0);

        // Single send: ack and router request one cycle after the request.
        bus.ni_data_i = {16'hDEAD, 16'hBEEF, 4'h3};
        bus.ni_req_i  = 1'b1;
        tick();
        chk("single_ack", bus.ni_ack_o, 1'b1);
        chk("single_rt_req", bus.rt_req_o, 1'b1);
        chk("single_rt_data", bus.rt_data_o, {16'h0012, 16'hBEEF, 4'h3});
        bus.ni_req_i = 1'b0;
        tick();
        chk("single_ack_pulse", bus.ni_ack_o, 1'b0);
        bus.rt_ack_i = 1'b1;
        tick();
        bus.rt_ack_i = 1'b0;
        chk("single_rt_req_after", bus.rt_req_o, 1'b0);
        chk("single_busy_after", bus.ni_busy_o, 1'b0);

        // Backpressure: five requests, router silent; only four fit.
        idx    = 0;
        n_acks = 0;
        bus.ni_data_i = {16'h0000, 16'hA000, 4'h5};
        bus.ni_req_i  = 1'b1;
        repeat (12) begin
            tick();
            if (bus.ni_ack_o) begin
                n_acks++;
                idx++;
                bus.ni_data_i = {16'h0000, 16'hA000 + 16'(idx), 4'h5};
            end
        end
        chk("bp_four_acks", n_acks, 4);
        chk("bp_busy_full", bus.ni_busy_o, 1'b1);
        bus.rt_ack_i = 1'b1;
        tick();
        bus.rt_ack_i = 1'b0;
        chk("bp_pop_no_same_cycle_push", bus.ni_ack_o, 1'b0);
        tick();
        chk("bp_fifth_ack", bus.ni_ack_o, 1'b1);
        bus.ni_req_i = 1'b0;
        bus.rt_ack_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            e = {8'(i + 1), OWN, 16'hA000 + 16'(i), 4'h5};
            chk("bp_order", bus.rt_data_o, e);
            tick();
        end
        bus.rt_ack_i = 1'b0;
        chk("bp_drained", bus.rt_req_o, 1'b0);

        // RX queue: four fit, fifth waits until the NI pops one.
        deliver({16'h1233, 16'h1111, 4'h1}, 10, got);
        chk("rx_ack_1", got, 1'b1);
        deliver({16'h1233, 16'h2222, 4'h1}, 10, got);
        chk("rx_ack_2", got, 1'b1);
        deliver({16'h1233, 16'h3333, 4'h1}, 10, got);
        chk("rx_ack_3", got, 1'b1);
        deliver({16'h1233, 16'h4444, 4'h1}, 10, got);
        chk("rx_ack_4", got, 1'b1);
        bus.rt_rx_data_i = {16'h1233, 16'h5555, 4'h1};
        bus.rt_rx_i      = 1'b1;
        n_acks = 0;
        repeat (6) begin
            tick();
            if (bus.rt_rx_ack_o) n_acks++;
        end
        chk("rx_fifth_held", n_acks, 0);
        chk("rx_head_1111", bus.ni_rx_data_o.payload, 16'h1111);
        ni_pop();
        chk("rx_head_2222", bus.ni_rx_data_o.payload, 16'h2222);
        tick();
        chk("rx_fifth_accepted", bus.rt_rx_ack_o, 1'b1);
        bus.rt_rx_i = 1'b0;
        chk("rx_head_2222_b", bus.ni_rx_data_o.payload, 16'h2222);
        ni_pop();
        chk("rx_head_3333", bus.ni_rx_data_o.payload, 16'h3333);
        ni_pop();
        chk("rx_head_4444", bus.ni_rx_data_o.payload, 16'h4444);
        ni_pop();
        chk("rx_head_5555", bus.ni_rx_data_o.payload, 16'h5555);
        ni_pop();
        chk("rx_empty", bus.ni_rx_o, 1'b0);
        ni_pop();
        chk("rx_pop_empty_ignored", bus.ni_rx_o, 1'b0);

        // Self-drop: acked, never queued; also acked while the queue is full.
        deliver({16'h0512, 16'h7777, 4'h1}, 10, got);
        chk("self_drop_ack", got, 1'b1);
        tick();
        chk("self_drop_not_queued", bus.ni_rx_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            deliver({16'h0033, 16'h6000 + 16'(i), 4'h2}, 10, got);
            chk("fill_ack", got, 1'b1);
        end
        deliver({16'h0912, 16'h7778, 4'h1}, 10, got);
        chk("self_drop_ack_when_full", got, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("fill_order", bus.ni_rx_data_o.payload, 16'h6000 + 16'(i));
            ni_pop();
        end

        // Same message on the instance that keeps its own broadcasts.
        bus2.rt_rx_data_i = {16'h0512, 16'h7777, 4'h1};
        bus2.rt_rx_i      = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bus2.rt_rx_ack_o) got = 1'b1;
        end
        bus2.rt_rx_i = 1'b0;
        chk("keep_self_ack", got, 1'b1);
        chk("keep_self_queued", bus2.ni_rx_o, 1'b1);
        chk("keep_self_data", bus2.ni_rx_data_o, {16'h0512, 16'h7777, 4'h1});

        // Reset with traffic in both queues.
        send(4'h4, 16'hC001);
        send(4'h4, 16'hC002);
        send(4'h4, 16'hC003);
        deliver({16'h0044, 16'hD001, 4'h3}, 10, got);
        deliver({16'h0044, 16'hD002, 4'h3}, 10, got);
        chk("pre_reset_busy", bus.ni_busy_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ni_ack", bus.ni_ack_o, 1'b0);
        chk("midrst_rt_rx_ack", bus.rt_rx_ack_o, 1'b0);
        chk("midrst_ni_busy", bus.ni_busy_o, 1'b0);
        chk("midrst_ni_rx", bus.ni_rx_o, 1'b0);
        chk("midrst_rt_req", bus.rt_req_o, 1'b0);
        send(4'h6, 16'hE000);
        chk("midrst_seq_00", bus.rt_data_o, {16'h0012, 16'hE000, 4'h6});
        bus.rt_ack_i = 1'b1;
        tick();
        bus.rt_ack_i = 1'b0;

        // Sequence wrap over 257 sends, router always ready.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rt_ack_i = 1'b1;
        for (int i = 0; i < 257; i++) begin
            send(4'h2, 16'(i));
            chk("wrap_seq", bus.rt_data_o.seq_source[15:8], i[7:0]);
        end
        tick();
        bus.rt_ack_i = 1'b0;
        tick();
        chk("wrap_drained", bus.rt_req_o, 1'b0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
